seg_approx_adder: RTL and testbench
===================================

# seg_approx_adder

Parametrised, sequential successor to the combinational ripple-carry adder used in the 16-bit adder blocks. It adds two `WIDTH`-bit operands split into `SEG`-bit segments under a valid/ready handshake, and runs in one of two modes selected per operation:

- **Exact mode** ripples the carry one segment per clock.
- **Approximate mode** uses the error-tolerant type II scheme, where each segment's carry-in is predicted from the segment below only, and completes in a single compute cycle.

It sits between operand sources and downstream consumers, which gives accuracy/latency trade-off studies a registered, back-pressurable adder.

## Interface

Parameters:
- `WIDTH`, default 16: operand and result width. Must be a multiple of `SEG`.
- `SEG`, default 4: segment width, with 1 ≤ `SEG` ≤ `WIDTH`. `NSEG` = `WIDTH`/`SEG` is derived.

Ports:
- `clk_i`  in  1  single clock; all state changes on the rising edge.
- `rst_n_i`  in  1  reset, asynchronous and active-low.
- `mode_i`  in  1  operation mode, 0 = exact, 1 = approximate (ETA-II). Sampled on accept.
- `in_valid_i`  in  1  operand valid.
- `in_ready_o`  out  1  block can accept operands.
- `add1_i`  in  `WIDTH`  operand A.
- `add2_i`  in  `WIDTH`  operand B.
- `carry_i`  in  1  carry-in to segment 0.
- `out_valid_o`  out  1  result valid.
- `out_ready_i`  in  1  consumer accepts the result.
- `result_o`  out  `WIDTH`  sum, registered.
- `carry_o`  out  1  carry-out of the top segment, registered.

## Operation

State machine: IDLE, CALC, DONE.

**IDLE**
- `in_ready_o` = 1, `out_valid_o` = 0.
- On `in_valid_i` && `in_ready_o`: register A, B, `carry_i` and `mode_i`; clear the segment index k to 0; go to CALC.

**CALC, exact mode**
- Each cycle: segment k sum = A[k] + B[k] + c, where c is the running carry (initially the registered `carry_i`).
- The `SEG`-bit sum is written into `result_o` bits [k·`SEG` +: `SEG`]. c takes that segment's carry-out.
- k increments each cycle. When k = `NSEG`−1 is processed, `carry_o` takes the final carry and the FSM goes to DONE.

**CALC, approximate mode (one cycle)**
- Segment 0 carry-in = registered `carry_i`.
- Segment j > 0 carry-in = carry-out of (A[j−1] + B[j−1] + 0). This uses the lower segment's operands only, with no chained propagation.
- All segments are summed in this cycle. `carry_o` = carry-out of segment `NSEG`−1 using its predicted carry-in. Then go to DONE.

**DONE**
- `out_valid_o` = 1.
- `result_o` and `carry_o` are held stable while `out_ready_i` = 0.
- On `out_ready_i` = 1, go to IDLE.

**Rules**
- `in_ready_o` = 1 only in IDLE. No accept occurs in CALC or DONE; `in_valid_i` is ignored there.
- Input changes after accept have no effect on the operation in flight.
- `result_o` bits not yet written during exact CALC keep their previous value. They are only meaningful while `out_valid_o` = 1.
- Arithmetic is modulo 2^`WIDTH`; overflow appears only on `carry_o`.
- With `SEG` = `WIDTH` (`NSEG` = 1), both modes give identical results in one CALC cycle.

**Reset (`rst_n_i` low, any time including mid-CALC or DONE)**
- State goes to IDLE; the in-flight operation is discarded.
- `out_valid_o` = 0, `result_o` = 0, `carry_o` = 0, k = 0, internal carry = 0.
- `in_ready_o` = 1 from reset assertion onward.

## Timing

- Accept edge is T.
- Exact mode: CALC spans `NSEG` cycles, so `out_valid_o` rises after edge T+`NSEG`.
- Approximate mode: `out_valid_o` rises after edge T+1.
- Output handshake: if `out_ready_i` = 1 during the first DONE cycle, `in_ready_o` returns to 1 after the next edge.
- Minimum issue interval: `NSEG`+2 cycles (exact), 3 cycles (approximate).
- All outputs are registered or decoded from the state register. There is no combinational path from any input to any output.

## Test plan

All scenarios use `WIDTH`=16, `SEG`=4 unless stated.

1. **Exact wrap-around.** Exact, A=0xFFFF, B=0x0001, cin=0 → `result_o`=0x0000, `carry_o`=1, `out_valid_o` rises 4 cycles after accept.
2. **Approximate on the same operands.** Approximate, A=0xFFFF, B=0x0001, cin=0 → `result_o`=0xFF00, `carry_o`=0, valid 1 cycle after accept. This checks segment-local carry prediction.
3. **No inter-segment carries.** A=0x1234, B=0x4321, cin=1, both modes → 0x5556, `carry_o`=0. Results match across modes.
4. **Backpressure and ignored input.** Hold `out_ready_i`=0 for 5 cycles in DONE → `result_o`/`carry_o` stay stable and `in_ready_o`=0. A new `in_valid_i` pulse during DONE is not accepted.
5. **Reset mid-operation.** Assert `rst_n_i` low during the second exact CALC cycle → `out_valid_o`=0, `result_o`=0, `carry_o`=0 immediately, `in_ready_o`=1. The next operation, 0x00FF+0x0001 exact, gives 0x0100.
6. **Degenerate segment.** `SEG`=16: A=0x8000, B=0x8000 in both modes → `result_o`=0x0000, `carry_o`=1, valid 1 cycle after accept.

Source files
------------

// File: rtl/seg_approx_adder.sv
// Segmented adder with a valid/ready handshake. Exact mode ripples the carry one
// segment per clock. Approximate mode (ETA-II) predicts each segment's carry-in from the segment below.
module seg_approx_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             mode_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  input  logic             carry_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o
);

  localparam int NSEG = WIDTH / SEG;
  localparam int KW   = (NSEG > 1) ? $clog2(NSEG) : 1;

  // Handshake: an input transfer happens on a rising edge with in_valid_i && in_ready_o.
  // An output transfer happens on a rising edge with out_valid_o && out_ready_i.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             mode_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             c_q, c_d;
  logic [KW-1:0]    k_q, k_d;

  logic             accept;
  logic [SEG:0]     ex_seg;
  logic [WIDTH-1:0] ap_result;
  logic             ap_carry;
  logic             ap_cin;
  logic [SEG:0]     ap_seg;
  logic [SEG:0]     ap_prev;

  assign accept = in_valid_i && (state_q == IDLE);

  // One segment of the rippling exact adder, selected by the segment index.
  assign ex_seg = {1'b0, a_q[int'(k_q)*SEG +: SEG]}
                + {1'b0, b_q[int'(k_q)*SEG +: SEG]}
                + {{SEG{1'b0}}, c_q};

  // ETA-II: the carry-in of segment j is the carry-out of A[j-1]+B[j-1]. It never chains.
  always_comb begin
    ap_result = '0;
    ap_carry  = 1'b0;
    ap_cin    = c_q;
    ap_seg    = '0;
    ap_prev   = '0;
    for (int j = 0; j < NSEG; j++) begin
      ap_seg  = {1'b0, a_q[j*SEG +: SEG]} + {1'b0, b_q[j*SEG +: SEG]}
              + {{SEG{1'b0}}, ap_cin};
      ap_result[j*SEG +: SEG] = ap_seg[SEG-1:0];
      ap_carry = ap_seg[SEG];
      ap_prev  = {1'b0, a_q[j*SEG +: SEG]} + {1'b0, b_q[j*SEG +: SEG]};
      ap_cin   = ap_prev[SEG];
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    c_d      = c_q;
    k_d      = k_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d = CALC;
          k_d     = '0;
          c_d     = carry_i;
        end
      end
      CALC: begin
        if (mode_q) begin
          result_d = ap_result;
          carry_d  = ap_carry;
          state_d  = DONE;
        end else begin
          result_d[int'(k_q)*SEG +: SEG] = ex_seg[SEG-1:0];
          c_d = ex_seg[SEG];
          if (k_q == KW'(NSEG - 1)) begin
            carry_d = ex_seg[SEG];
            state_d = DONE;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      c_q      <= 1'b0;
      k_q      <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      c_q      <= c_d;
      k_q      <= k_d;
      if (accept) begin
        a_q    <= add1_i;
        b_q    <= add2_i;
        mode_q <= mode_i;
      end
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign result_o    = result_q;
  assign carry_o     = carry_q;

endmodule

// File: tb/tb_seg_approx_adder.sv
// Scoreboarded bench for seg_approx_adder. It drives a SEG=4 instance and a SEG=16 instance
// with directed vectors whose expected results were worked out by hand.
module tb_seg_approx_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // SEG=4 instance
  logic        mode, in_valid, in_ready, carry_in, out_valid, out_ready, carry_out;
  logic [15:0] add1, add2, result;
  // SEG=16 instance
  logic        mode_w, in_valid_w, in_ready_w, carry_in_w, out_valid_w, out_ready_w, carry_out_w;
  logic [15:0] add1_w, add2_w, result_w;

  seg_approx_adder #(.WIDTH(16), .SEG(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .mode_i(mode), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .add1_i(add1), .add2_i(add2), .carry_i(carry_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result),
    .carry_o(carry_out)
  );

  seg_approx_adder #(.WIDTH(16), .SEG(16)) dut_w (
    .clk_i(clk), .rst_n_i(rst_n), .mode_i(mode_w), .in_valid_i(in_valid_w),
    .in_ready_o(in_ready_w), .add1_i(add1_w), .add2_i(add2_w), .carry_i(carry_in_w),
    .out_valid_o(out_valid_w), .out_ready_i(out_ready_w), .result_o(result_w),
    .carry_o(carry_out_w)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected entry: {latency[7:0], carry, result[15:0]}
  logic [24:0] exp_q[$];
  logic [24:0] exp_w_q[$];
  int          acc_q[$];
  int          acc_w_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitors: compare on the first cycle a result is presented.
  logic prev_v = 1'b0, prev_v_w = 1'b0;
  always @(negedge clk) begin
    logic [24:0] e;
    int          a;
    if (out_valid && !prev_v) begin
      if (exp_q.size() == 0 || acc_q.size() == 0) flag("unexpected_output_seg4");
      else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check("result_seg4", 32'(result), 32'(e[15:0]));
        check("carry_seg4", 32'(carry_out), 32'(e[16]));
        check("latency_seg4", 32'(cyc - a), 32'(e[24:17]));
      end
    end
    prev_v <= out_valid;
  end

  always @(negedge clk) begin
    logic [24:0] e;
    int          a;
    if (out_valid_w && !prev_v_w) begin
      if (exp_w_q.size() == 0 || acc_w_q.size() == 0) flag("unexpected_output_seg16");
      else begin
        e = exp_w_q.pop_front();
        a = acc_w_q.pop_front();
        check("result_seg16", 32'(result_w), 32'(e[15:0]));
        check("carry_seg16", 32'(carry_out_w), 32'(e[16]));
        check("latency_seg16", 32'(cyc - a), 32'(e[24:17]));
      end
    end
    prev_v_w <= out_valid_w;
  end

  task automatic issue(input bit w, input bit md, input logic [15:0] a, input logic [15:0] b,
                       input bit ci, input logic [15:0] er, input bit ec, input int lat);
    int t = 0;
    if (w) exp_w_q.push_back({8'(lat), ec, er});
    else   exp_q.push_back({8'(lat), ec, er});
    @(negedge clk);
    if (w) begin mode_w = md; add1_w = a; add2_w = b; carry_in_w = ci; in_valid_w = 1'b1; end
    else   begin mode = md; add1 = a; add2 = b; carry_in = ci; in_valid = 1'b1; end
    while (!(w ? in_ready_w : in_ready) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) flag("accept_timeout");
    else begin
      @(posedge clk);
      #1;
      if (w) acc_w_q.push_back(cyc);
      else   acc_q.push_back(cyc);
    end
    // Scramble inputs after accept; the operation in flight must not see them.
    if (w) begin mode_w = ~md; add1_w = ~a; add2_w = ~b; carry_in_w = ~ci; in_valid_w = 1'b0; end
    else   begin mode = ~md; add1 = ~a; add2 = ~b; carry_in = ~ci; in_valid = 1'b0; end
  endtask

  task automatic wait_idle(input bit w);
    int t = 0;
    @(negedge clk);
    while (!(w ? in_ready_w : in_ready) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) flag("idle_timeout");
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    {mode, in_valid, carry_in, add1, add2} = '0;
    {mode_w, in_valid_w, carry_in_w, add1_w, add2_w} = '0;
    out_ready = 1'b1;
    out_ready_w = 1'b1;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    check("rst_in_ready_w", 32'(in_ready_w), 32'd1);
    check("rst_out_valid_w", 32'(out_valid_w), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(0, 0, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 4); wait_idle(0);
    issue(0, 1, 16'hFFFF, 16'h0001, 0, 16'hFF00, 0, 1); wait_idle(0);
    issue(0, 0, 16'h1234, 16'h4321, 1, 16'h5556, 0, 4); wait_idle(0);
    issue(0, 1, 16'h1234, 16'h4321, 1, 16'h5556, 0, 1); wait_idle(0);
    issue(0, 0, 16'h8000, 16'h8000, 0, 16'h0000, 1, 4); wait_idle(0);
    issue(0, 1, 16'h8000, 16'h8000, 0, 16'h0000, 1, 1); wait_idle(0);
    issue(0, 0, 16'h0FF0, 16'h0010, 0, 16'h1000, 0, 4); wait_idle(0);
    issue(0, 1, 16'h0FF0, 16'h0010, 0, 16'h0000, 0, 1); wait_idle(0);

    // Backpressure: hold the result for 5 cycles and pulse in_valid meanwhile.
    out_ready = 1'b0;
    issue(0, 0, 16'h00AA, 16'h0055, 1, 16'h0100, 0, 4);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) flag("bp_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_result", 32'(result), 32'h0100);
      check("bp_carry", 32'(carry_out), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      if (i == 1) begin mode = 1'b1; add1 = 16'h1111; add2 = 16'h1111; in_valid = 1'b1; end
      if (i == 3) in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("bp_no_hidden_accept", 32'(out_valid), 32'd0);

    // Reset during the second exact CALC cycle.
    issue(0, 0, 16'h1234, 16'h1111, 0, 16'h0000, 0, 4);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_carry", 32'(carry_out), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 0, 16'h00FF, 16'h0001, 0, 16'h0100, 0, 4); wait_idle(0);

    // Single-segment instance: both modes agree in one CALC cycle.
    issue(1, 0, 16'h8000, 16'h8000, 0, 16'h0000, 1, 1); wait_idle(1);
    issue(1, 1, 16'h8000, 16'h8000, 0, 16'h0000, 1, 1); wait_idle(1);
    issue(1, 1, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 1); wait_idle(1);
    issue(1, 0, 16'h1234, 16'h4321, 1, 16'h5556, 0, 1); wait_idle(1);

    repeat (3) @(negedge clk);
    check("pending_expectations", 32'(exp_q.size() + exp_w_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
